// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DefaultWidth = 32;

  typedef logic [DefaultWidth-1:0] operand_t;
  typedef logic [DefaultWidth:0]   prem_t;

  // Width of the iteration counter; must hold BitWidth-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider core (combinational).
module div_step
  import divider_pkg::*;
#(
  parameter int BitWidth = 32
) (
  input  logic [BitWidth-1:0] rem,
  input  logic [BitWidth-1:0] quo,
  input  logic [BitWidth:0]   dsr,
  output logic [BitWidth-1:0] rem_next,
  output logic [BitWidth-1:0] quo_next
);

  logic [BitWidth:0] shifted_s;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    shifted_s = {rem, quo[BitWidth-1]};
    rem_next  = shifted_s[BitWidth-1:0];
    quo_next  = {quo[BitWidth-2:0], 1'b0};
    if (shifted_s >= dsr) begin
      // True difference is below the divisor, so the low bits are exact.
      rem_next = shifted_s[BitWidth-1:0] - dsr[BitWidth-1:0];
      quo_next = {quo[BitWidth-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[BitWidth-1:0];
      quo_next = {quo[BitWidth-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned restoring divider (MIPS DIV/DIVU).
// Optional macro DIVIDER_ZERO_FAST_EN: divide-by-zero skips the iteration phase.
module iterative_divider
  import divider_pkg::*;
#(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cancel,
  input  logic                isUnsigned,
  input  logic [BitWidth-1:0] dividend,
  input  logic [BitWidth-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [BitWidth-1:0] quotient,
  output logic [BitWidth-1:0] remainder,
  output logic                divByZero
);

  localparam int CntW = cnt_width(BitWidth);

  typedef logic [BitWidth-1:0] word_t;
  typedef logic [BitWidth:0]   wide_t;
  typedef logic [CntW-1:0]     cnt_t;

  localparam word_t WordZero = {BitWidth{1'b0}};
  localparam word_t WordOnes = {BitWidth{1'b1}};
  localparam word_t WordOne  = {{(BitWidth-1){1'b0}}, 1'b1};
  localparam cnt_t  CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam cnt_t  CntZero  = {CntW{1'b0}};
  localparam cnt_t  CntLast  = cnt_t'(BitWidth - 1);

  // Two's-complement magnitude; s is only set for negative x, so INT_MIN maps to 2^(W-1).
  function automatic word_t magnitude(input word_t x, input logic s);
    return (x ^ {BitWidth{s}}) + {{(BitWidth-1){1'b0}}, s};
  endfunction

  div_state_e state_r, next_s;
  logic       load_s, step_s, fin_s;

  cnt_t  cnt_r;
  word_t rem_r, quo_r, dvd_r;
  wide_t dsr_r;
  logic  sign_a_r, sign_b_r, zero_r;

  word_t quotient_r, remainder_r;
  logic  busy_r, done_r, dbz_r;

  logic  sign_a_s, sign_b_s, zero_s;
  word_t rem_next_s, quo_next_s;
  word_t res_q_s, res_r_s;

  assign sign_a_s = ~isUnsigned & dividend[BitWidth-1];
  assign sign_b_s = ~isUnsigned & divisor[BitWidth-1];
  assign zero_s   = (divisor == WordZero);

  div_step #(.BitWidth(BitWidth)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dsr      (dsr_r),
    .rem_next (rem_next_s),
    .quo_next (quo_next_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and datapath control; cancel wins over everything outside IDLE.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    fin_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !cancel) begin
          load_s = 1'b1;
`ifdef DIVIDER_ZERO_FAST_EN
          if (zero_s) begin
            next_s = FIX;
          end else begin
            next_s = CALC;
          end
`else
          next_s = CALC;
`endif
        end else begin
          next_s = IDLE;
        end
      end
      CALC: begin
        if (cancel) begin
          next_s = IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == CntZero) begin
            next_s = FIX;
          end else begin
            next_s = CALC;
          end
        end
      end
      FIX: begin
        next_s = IDLE;
        if (!cancel) begin
          fin_s = 1'b1;
        end else begin
          fin_s = 1'b0;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Sign correction and forced divide-by-zero results.
  always_comb begin
    res_q_s = quo_r;
    res_r_s = rem_r;
    if (zero_r) begin
      res_q_s = sign_a_r ? WordOne : WordOnes;
      res_r_s = dvd_r;
    end else begin
      res_q_s = (sign_a_r ^ sign_b_r) ? (WordZero - quo_r) : quo_r;
      res_r_s = sign_a_r ? (WordZero - rem_r) : rem_r;
    end
  end

  // Operand capture and one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= CntZero;
      rem_r    <= WordZero;
      quo_r    <= WordZero;
      dvd_r    <= WordZero;
      dsr_r    <= {1'b0, WordZero};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      zero_r   <= 1'b0;
    end else if (load_s) begin
      cnt_r    <= CntLast;
      rem_r    <= WordZero;
      quo_r    <= magnitude(dividend, sign_a_s);
      dvd_r    <= dividend;
      dsr_r    <= {1'b0, magnitude(divisor, sign_b_s)};
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      zero_r   <= zero_s;
    end else if (step_s) begin
      rem_r <= rem_next_s;
      quo_r <= quo_next_s;
      if (cnt_r != CntZero) begin
        cnt_r <= cnt_r - CntOne;
      end else begin
        cnt_r <= CntZero;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered handshake and result outputs; results hold until the next done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= WordZero;
      remainder_r <= WordZero;
      dbz_r       <= 1'b0;
    end else begin
      busy_r <= (next_s != IDLE);
      done_r <= fin_s;
      if (fin_s) begin
        quotient_r  <= res_q_s;
        remainder_r <= res_r_s;
        dbz_r       <= zero_r;
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
        dbz_r       <= dbz_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign divByZero = dbz_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed, table-driven bench for iterative_divider (BitWidth=32).
module tb_iterative_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic         isUnsigned = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, divByZero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  iterative_divider #(.BitWidth(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cancel     (cancel),
    .isUnsigned (isUnsigned),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .divByZero  (divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic dz);
`ifdef DIVIDER_ZERO_FAST_EN
    return dz ? 2 : 34;
`else
    return 34;
`endif
  endfunction

  // Drive a request for one sampling edge; returns in cycle 1 of the operation.
  task automatic issue(input logic u, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    isUnsigned = u;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the cycle index of done, busy must be high until then.
  task automatic wait_done(input int c0, output int lat, output logic busy_ok);
    lat = c0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  // Watch n cycles and report whether done pulsed.
  task automatic watch_no_done(input int n, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int   lat;
    logic bok;
    logic seen;

    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[6]  = '{1'b0, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB,   1'b1};
    vecs[7]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[11] = '{1'b0, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, divByZero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: each request issued in the done cycle of the previous one
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].uns, vecs[i].a, vecs[i].b);
      wait_done(1, lat, bok);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].dz));
      check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), {31'd0, divByZero}, {31'd0, vecs[i].dz});
    end

    // Back-to-back: start in the done cycle
    @(posedge clk);
    #1;
    issue(1'b1, 32'd100, 32'd7);
    wait_done(1, lat, bok);
    check("b2b_first_q", quotient, 32'd14);
    issue(1'b1, 32'd81, 32'd9);
    wait_done(1, lat, bok);
    check("b2b_latency", lat, 32'd34);
    check("b2b_quotient", quotient, 32'd9);
    check("b2b_remainder", remainder, 32'd0);

    // start while busy is ignored
    @(posedge clk);
    #1;
    issue(1'b1, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    dividend = 32'd81;
    divisor = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, lat, bok);
    check("ignore_latency", lat, 32'd34);
    check("ignore_quotient", quotient, 32'd14);
    check("ignore_remainder", remainder, 32'd2);

    // cancel at cycle 15: no done, outputs unchanged
    @(posedge clk);
    #1;
    issue(1'b1, 32'd81, 32'd9);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    watch_no_done(40, seen);
    check("cancel_no_done", {31'd0, seen}, 32'd0);
    check("cancel_quotient", quotient, 32'd14);
    check("cancel_remainder", remainder, 32'd2);

    // cancel together with start in IDLE drops the start
    start = 1'b1;
    cancel = 1'b1;
    isUnsigned = 1'b1;
    dividend = 32'd81;
    divisor = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
    check("idle_cancel_busy", {31'd0, busy}, 32'd0);
    watch_no_done(40, seen);
    check("idle_cancel_no_done", {31'd0, seen}, 32'd0);

    // asynchronous reset at cycle 20
    issue(1'b1, 32'd100, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(40, seen);
    check("rst_no_done", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
